// File: rtl/cipher_pkg.sv
// Shared definitions for the cipher engine: FSM state encoding, cipher mode
// encoding and the letter-rotation helpers used by Caesar and Vigenere modes.
package cipher_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StKey  = 2'd1,
    StRun  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ModeBypass   = 2'd0,
    ModeCaesar   = 2'd1,
    ModeVigenere = 2'd2,
    ModeXor      = 2'd3
  } mode_e;

  function automatic logic is_upper(logic [7:0] c);
    return (c >= 8'h41) && (c <= 8'h5A);
  endfunction

  function automatic logic is_lower(logic [7:0] c);
    return (c >= 8'h61) && (c <= 8'h7A);
  endfunction

  function automatic logic is_letter(logic [7:0] c);
    return is_upper(c) || is_lower(c);
  endfunction

  // Letter keys map 'a'/'A' to 0; anything else is taken mod 26.
  function automatic logic [4:0] key_shift(logic [7:0] k);
    logic [7:0] s;
    if (is_upper(k)) begin
      s = k - 8'h41;
    end else if (is_lower(k)) begin
      s = k - 8'h61;
    end else begin
      s = k % 8'd26;
    end
    return s[4:0];
  endfunction

  // Rotate a letter by s within its case; non-letters pass unchanged.
  function automatic logic [7:0] rotate_char(logic [7:0] c, logic [4:0] s, logic dec);
    logic [7:0] base;
    logic [7:0] off;
    logic [5:0] r;
    if (!is_letter(c)) begin
      return c;
    end
    base = is_upper(c) ? 8'h41 : 8'h61;
    off  = c - base;
    // off and s are both < 26, so one conditional subtract completes the mod.
    if (dec) begin
      r = off[5:0] + 6'd26 - {1'b0, s};
    end else begin
      r = off[5:0] + {1'b0, s};
    end
    if (r >= 6'd26) begin
      r = r - 6'd26;
    end
    return base + {2'b00, r};
  endfunction

endpackage

// File: rtl/cipher_if.sv
// Character stream interface: input side (in_valid/in_ready/in_char) and
// output side (out_valid/out_ready/out_char).
// master: the environment feeding characters and consuming results.
// slave : the cipher engine.
interface cipher_if #(
  parameter int unsigned DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_char;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_char;

  modport master (
    output in_valid, in_char, out_ready,
    input  in_ready, out_valid, out_char
  );

  modport slave (
    input  in_valid, in_char, out_ready,
    output in_ready, out_valid, out_char
  );
endinterface

// File: rtl/cipher_fifo.sv
// Output FIFO for the cipher engine.
// Ports: clk, reset (sync, active-high), flush (empties in the same cycle),
// push/wdata (caller guarantees no push when full), pop (ignored when empty),
// rdata/valid (head of queue, zero when empty), count (occupancy).
module cipher_fifo #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned OUT_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             push,
  input  logic [DATA_W-1:0]                wdata,
  input  logic                             pop,
  output logic [DATA_W-1:0]                rdata,
  output logic                             valid,
  output logic [$clog2(OUT_DEPTH+1)-1:0]   count
);
  localparam int unsigned AW = $clog2(OUT_DEPTH);
  localparam int unsigned CW = $clog2(OUT_DEPTH + 1);

  logic [DATA_W-1:0] mem_q [OUT_DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [CW-1:0]     count_q;
  logic              do_pop;

  assign valid  = (count_q != '0);
  assign do_pop = pop && valid;
  assign count  = count_q;
  // Gate the head so stale storage is never visible while empty.
  assign rdata  = valid ? mem_q[rd_q] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_q <= wr_q + AW'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + AW'(1);
      end
      case ({push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cipher_engine.sv
// Streaming character cipher: bypass, Caesar, Vigenere and XOR modes.
// Ports: clk, reset (sync, active-high); mode/decrypt latched on RUN entry;
// key_start/key_done/abort control pulses; bus (character in/out handshakes);
// state (0 IDLE, 1 KEY, 2 RUN), key_len, fifo_count status outputs.
module cipher_engine
  import cipher_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned KEY_DEPTH = 16,
  parameter int unsigned OUT_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [1:0]                       mode,
  input  logic                             decrypt,
  input  logic                             key_start,
  input  logic                             key_done,
  input  logic                             abort,
  cipher_if.slave                          bus,
  output logic [1:0]                       state,
  output logic [$clog2(KEY_DEPTH+1)-1:0]   key_len,
  output logic [$clog2(OUT_DEPTH+1)-1:0]   fifo_count
);
  localparam int unsigned KLW = $clog2(KEY_DEPTH + 1);
  localparam int unsigned KIW = $clog2(KEY_DEPTH);
  localparam int unsigned FCW = $clog2(OUT_DEPTH + 1);
  localparam logic [KLW-1:0] KeyFull  = KLW'(KEY_DEPTH);
  localparam logic [FCW-1:0] FifoFull = FCW'(OUT_DEPTH);

  state_e            state_q;
  logic [7:0]        key_q [KEY_DEPTH];
  logic [KLW-1:0]    key_len_q;
  logic [KIW-1:0]    kidx_q;
  mode_e             mode_q;
  logic              dec_q;

  logic              in_fire, push, enter_run, advance;
  logic [7:0]        lo, kchar;
  logic [DATA_W-1:0] xform;

  assign lo        = bus.in_char[7:0];
  assign kchar     = key_q[kidx_q];
  assign in_fire   = bus.in_valid && bus.in_ready;
  assign push      = in_fire && (state_q == StRun) && !abort;
  // Both IDLE and KEY enter RUN on key_done when a key is stored.
  assign enter_run = !abort && key_done && (key_len_q != '0) &&
                     ((state_q == StIdle) || (state_q == StKey));

  assign state   = state_q;
  assign key_len = key_len_q;

  always_comb begin
    case (state_q)
      StKey:   bus.in_ready = (key_len_q < KeyFull);
      StRun:   bus.in_ready = (fifo_count < FifoFull);
      default: bus.in_ready = 1'b0;
    endcase
  end

  always_comb begin
    xform   = bus.in_char;
    advance = 1'b0;
    case (mode_q)
      ModeCaesar: xform[7:0] = rotate_char(lo, key_shift(key_q[0]), dec_q);
      ModeVigenere: begin
        xform[7:0] = rotate_char(lo, key_shift(kchar), dec_q);
        advance    = is_letter(lo);
      end
      ModeXor: begin
        xform[7:0] = lo ^ kchar;
        advance    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      key_len_q <= '0;
      kidx_q    <= '0;
      mode_q    <= ModeBypass;
      dec_q     <= 1'b0;
    end else if (abort) begin
      state_q <= StIdle;
    end else if (enter_run) begin
      state_q <= StRun;
      mode_q  <= mode_e'(mode);
      dec_q   <= decrypt;
      kidx_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (key_start) begin
            state_q   <= StKey;
            key_len_q <= '0;
          end
        end
        StKey: begin
          // key_done here means an empty key; a character in that cycle is dropped.
          if (key_done) begin
            state_q <= StIdle;
          end else if (in_fire) begin
            key_q[key_len_q[KIW-1:0]] <= lo;
            key_len_q                 <= key_len_q + KLW'(1);
          end
        end
        StRun: begin
          if (in_fire && advance) begin
            if (KLW'(kidx_q) + KLW'(1) >= key_len_q) begin
              kidx_q <= '0;
            end else begin
              kidx_q <= kidx_q + KIW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  cipher_fifo #(
    .DATA_W    (DATA_W),
    .OUT_DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (abort),
    .push  (push),
    .wdata (xform),
    .pop   (bus.out_ready),
    .rdata (bus.out_char),
    .valid (bus.out_valid),
    .count (fifo_count)
  );

endmodule
